// File: rtl/bcd_accum_pkg.sv
// Shared types and constants for the digit-serial BCD accumulator controller.
package bcd_accum_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_accum_ctrl_if.sv
// Strobe inputs and display/status outputs of the BCD accumulator controller.
interface bcd_accum_ctrl_if #(
  parameter int DIGITS = 4
);
  import bcd_accum_pkg::*;

  logic                        digit_stb;
  logic [DIGIT_W-1:0]          digit;
  logic                        add_stb;
  logic                        sub_stb;
  logic                        clr_stb;
  logic [DIGIT_W*DIGITS-1:0]   disp;
  logic                        busy;
  logic                        done;
  logic                        carry;
  logic                        show_acc;

  modport master (
    output digit_stb, digit, add_stb, sub_stb, clr_stb,
    input  disp, busy, done, carry, show_acc
  );

  modport slave (
    input  digit_stb, digit, add_stb, sub_stb, clr_stb,
    output disp, busy, done, carry, show_acc
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder: binary sum with +6 correction above 9.
module bcd_digit_add
  import bcd_accum_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               ci_i,
  output logic [DIGIT_W-1:0] s_o,
  output logic               co_o
);

  logic [DIGIT_W:0] binSum;

  always_comb begin
    binSum = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_W{1'b0}}, ci_i};
    if (binSum > {1'b0, BCD_MAX}) begin
      s_o  = binSum[DIGIT_W-1:0] + DIGIT_W'(6);
      co_o = 1'b1;
    end else begin
      s_o  = binSum[DIGIT_W-1:0];
      co_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_accum_ctrl.sv
// Digit-serial BCD accumulator controller: acc = acc + entry over DIGITS cycles.
// Subtraction (acc - entry, nines-complement) is built only with BCD_ACCUM_SUB_EN.
module bcd_accum_ctrl
  import bcd_accum_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                hz100,
  input  logic                reset,
  bcd_accum_ctrl_if.slave     bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       entry_q, entry_d;
  logic [W-1:0]       acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               cin_q, cin_d;
  logic [IDX_W-1:0]   digitIdx_q, digitIdx_d;
  logic               showAcc_q, showAcc_d;

  logic               startOp;
  logic               startSub;
  logic               subOp;
  logic [DIGIT_W-1:0] addB;
  logic [DIGIT_W-1:0] sumDigit;
  logic               sumCarry;

`ifdef BCD_ACCUM_SUB_EN
  logic subOp_q, subOp_d;

  assign startSub = bus.sub_stb && !bus.add_stb;
  assign startOp  = bus.add_stb || bus.sub_stb;
  assign subOp    = subOp_q;
  assign addB     = subOp_q ? (BCD_MAX - entry_q[DIGIT_W-1:0]) : entry_q[DIGIT_W-1:0];

  always_comb begin
    subOp_d = subOp_q;
    if (bus.clr_stb)
      subOp_d = 1'b0;
    else if (state_q == S_IDLE && startOp)
      subOp_d = startSub;
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) subOp_q <= 1'b0;
    else       subOp_q <= subOp_d;
  end
`else
  logic unused_sub;

  assign unused_sub = bus.sub_stb;
  assign startSub   = 1'b0;
  assign startOp    = bus.add_stb;
  assign subOp      = 1'b0;
  assign addB       = entry_q[DIGIT_W-1:0];
`endif

  bcd_digit_add u_add (
    .a_i  (acc_q[DIGIT_W-1:0]),
    .b_i  (addB),
    .ci_i (cin_q),
    .s_o  (sumDigit),
    .co_o (sumCarry)
  );

  // Clear overrides everything; in RUN both registers rotate so the LSD always feeds the adder.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    cin_d      = cin_q;
    digitIdx_d = digitIdx_q;
    showAcc_d  = showAcc_q;

    if (bus.clr_stb) begin
      state_d    = S_IDLE;
      entry_d    = '0;
      acc_d      = '0;
      carry_d    = 1'b0;
      cin_d      = 1'b0;
      digitIdx_d = '0;
      showAcc_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startOp) begin
            carry_d    = 1'b0;
            cin_d      = startSub;
            digitIdx_d = '0;
            state_d    = S_RUN;
          end else if (bus.digit_stb && bus.digit <= BCD_MAX) begin
            entry_d   = {entry_q[W-DIGIT_W-1:0], bus.digit};
            showAcc_d = 1'b0;
          end
        end
        S_RUN: begin
          acc_d      = {sumDigit, acc_q[W-1:DIGIT_W]};
          entry_d    = {entry_q[DIGIT_W-1:0], entry_q[W-1:DIGIT_W]};
          cin_d      = sumCarry;
          digitIdx_d = digitIdx_q + IDX_W'(1);
          if (digitIdx_q == LAST_IDX)
            state_d = S_DONE;
        end
        S_DONE: begin
          carry_d   = subOp ? ~cin_q : cin_q;
          entry_d   = '0;
          showAcc_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cin_q      <= 1'b0;
      digitIdx_q <= '0;
      showAcc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cin_q      <= cin_d;
      digitIdx_q <= digitIdx_d;
      showAcc_q  <= showAcc_d;
    end
  end

  assign bus.disp     = showAcc_q ? acc_q : entry_q;
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.carry    = carry_q;
  assign bus.show_acc = showAcc_q;

endmodule
